// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit feeder slice.
package uart_pkg;

  localparam int DATA_W   = 8;
  localparam int TX_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DONE = 2'd2
  } txState_t;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Producer-side and transmitter-side signals of uart_tx_feeder bundled as one interface.
interface uart_tx_feeder_if
  import uart_pkg::*;
#(
  parameter int ADDR_W = 4
);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ADDR_W:0]   fifo_count;
  logic              TxD_start;
  logic [DATA_W-1:0] TxD_data;
  logic              TxD_busy;
  logic              idle;

  modport master (
    output wr_en, wr_data, TxD_busy,
    input  fifo_full, fifo_empty, fifo_count, TxD_start, TxD_data, idle
  );

  modport slave (
    input  wr_en, wr_data, TxD_busy,
    output fifo_full, fifo_empty, fifo_count, TxD_start, TxD_data, idle
  );

endinterface

// File: rtl/byte_fifo.sv
// Register-based byte FIFO with registered full/empty/count that reflect the post-edge state.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wrData,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              emptyNext
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ZERO_CNT = {(ADDR_W + 1){1'b0}};
  localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W + 1)'(1);

  logic [DATA_W-1:0] memR [DEPTH];
  logic [ADDR_W-1:0] wrPtrR;
  logic [ADDR_W-1:0] rdPtrR;
  logic [ADDR_W:0]   countR;
  logic [ADDR_W:0]   countS;
  logic              fullR;
  logic              emptyR;
  logic              pushOkS;
  logic              popOkS;

  // Accept decisions use the flags from the start of the cycle, so a push while full is dropped even if a pop happens.
  always_comb begin
    pushOkS = push && !fullR;
    popOkS  = pop && !emptyR;
    countS  = countR;
    if (pushOkS && !popOkS) begin
      countS = countR + ONE_CNT;
    end else if (popOkS && !pushOkS) begin
      countS = countR - ONE_CNT;
    end else begin
      countS = countR;
    end
  end

  // Storage array; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (pushOkS) begin
      memR[wrPtrR] <= wrData;
    end
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtrR <= {ADDR_W{1'b0}};
      rdPtrR <= {ADDR_W{1'b0}};
      countR <= ZERO_CNT;
      fullR  <= 1'b0;
      emptyR <= 1'b1;
    end else begin
      if (pushOkS) begin
        wrPtrR <= wrPtrR + ADDR_W'(1);
      end
      if (popOkS) begin
        rdPtrR <= rdPtrR + ADDR_W'(1);
      end
      countR <= countS;
      fullR  <= (countS == FULL_CNT);
      emptyR <= (countS == ZERO_CNT);
    end
  end

  assign head      = memR[rdPtrR];
  assign full      = fullR;
  assign empty     = emptyR;
  assign count     = countR;
  assign emptyNext = (countS == ZERO_CNT);

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffered byte source for async_transmitter: pops the FIFO and paces TxD_start on TxD_busy.
// Define TX_COUNT_EN to add the tx_count frame counter and the sticky overflow flag.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic clk,
  input  logic reset,
  uart_tx_feeder_if.slave bus
`ifdef TX_COUNT_EN
  ,
  output logic [TX_CNT_W-1:0] tx_count,
  output logic [0:0]          overflow
`endif
);

  txState_t          stateR;
  txState_t          stateS;
  logic              startR;
  logic              startS;
  logic [DATA_W-1:0] dataR;
  logic [DATA_W-1:0] dataS;
  logic              idleR;
  logic              idleS;
  logic              popS;
  logic [DATA_W-1:0] headS;
  logic              fifoFullS;
  logic              fifoEmptyS;
  logic [ADDR_W:0]   fifoCountS;
  logic              emptyNextS;

  byte_fifo #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (bus.wr_en),
    .pop      (popS),
    .wrData   (bus.wr_data),
    .head     (headS),
    .full     (fifoFullS),
    .empty    (fifoEmptyS),
    .count    (fifoCountS),
    .emptyNext(emptyNextS)
  );

  // Next-state and next-output logic; the head byte is captured in the same cycle it is popped.
  always_comb begin
    stateS = stateR;
    startS = startR;
    dataS  = dataR;
    popS   = 1'b0;
    case (stateR)
      IDLE: begin
        if (!fifoEmptyS && !bus.TxD_busy) begin
          popS   = 1'b1;
          dataS  = headS;
          startS = 1'b1;
          stateS = REQ;
        end else begin
          startS = 1'b0;
          stateS = IDLE;
        end
      end
      REQ: begin
        if (bus.TxD_busy) begin
          startS = 1'b0;
          stateS = WAIT_DONE;
        end else begin
          startS = 1'b1;
          stateS = REQ;
        end
      end
      WAIT_DONE: begin
        startS = 1'b0;
        if (!bus.TxD_busy) begin
          stateS = IDLE;
        end else begin
          stateS = WAIT_DONE;
        end
      end
      default: begin
        startS = 1'b0;
        stateS = IDLE;
      end
    endcase
    idleS = emptyNextS && (stateS == IDLE);
  end

  // FSM state and registered transmitter-facing outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateR <= IDLE;
      startR <= 1'b0;
      dataR  <= {DATA_W{1'b0}};
      idleR  <= 1'b1;
    end else begin
      stateR <= stateS;
      startR <= startS;
      dataR  <= dataS;
      idleR  <= idleS;
    end
  end

`ifdef TX_COUNT_EN
  logic [TX_CNT_W-1:0] txCountR;
  logic                overflowR;

  // Frames handed off (counted on REQ->WAIT_DONE) and sticky record of a push lost to a full FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      txCountR  <= {TX_CNT_W{1'b0}};
      overflowR <= 1'b0;
    end else begin
      if ((stateR == REQ) && bus.TxD_busy) begin
        txCountR <= txCountR + TX_CNT_W'(1);
      end
      if (bus.wr_en && fifoFullS) begin
        overflowR <= 1'b1;
      end
    end
  end

  assign tx_count = txCountR;
  assign overflow = overflowR;
`endif

  assign bus.fifo_full  = fifoFullS;
  assign bus.fifo_empty = fifoEmptyS;
  assign bus.fifo_count = fifoCountS;
  assign bus.TxD_start  = startR;
  assign bus.TxD_data   = dataR;
  assign bus.idle       = idleR;

endmodule
